// File: rtl/game_pkg.sv
// Shared definitions for the VGA shooter: datapath op codes, draw-sequencer
// state codes and the player fire FSM encoding.
package game_pkg;

  localparam logic [1:0] OP_DRAW  = 2'b00;
  localparam logic [1:0] OP_ERASE = 2'b01;
  localparam logic [1:0] OP_SHOT  = 2'b10;

  localparam logic [3:0] SELF_DRAW  = 4'd1;
  localparam logic [3:0] SELF_ERASE = 4'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACTIVE = 2'b01,
    ST_COOL   = 2'b10
  } fire_state_e;

endpackage : game_pkg

// File: rtl/rate_tick.sv
// Free-running modulo-PERIOD counter producing a one-cycle tick on its last count.
module rate_tick #(
  parameter int unsigned PERIOD = 25000000
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick_o
);

  localparam int unsigned CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Wrap at PERIOD-1 so the tick repeats every PERIOD clocks.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = (cnt_q == LAST);

endmodule : rate_tick

// File: rtl/player_ctrl.sv
// Player-ship controller: button sync, rate-limited clamped movement, fire FSM
// with hold/cooldown/auto-fire, and sprite datapath op decode.
module player_ctrl
  import game_pkg::*;
#(
  parameter int unsigned X_W         = 8,
  parameter int unsigned X_MIN       = 2,
  parameter int unsigned X_MAX       = 150,
  parameter int unsigned X_RESET     = 82,
  parameter int unsigned STEP        = 10,
  parameter int unsigned MOVE_PERIOD = 25000000,
  parameter int unsigned FIRE_HOLD   = 1250000,
  parameter int unsigned FIRE_COOL   = 37500000
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [3:0]     key_n,
  input  logic [3:0]     self_state,
  output logic [1:0]     op,
  output logic           self_enable,
  output logic [X_W-1:0] x,
  output logic           fire_active,
  output logic           fire_start,
  output logic [X_W-1:0] fire_x
);

  localparam int unsigned XW1    = X_W + 1;
  localparam int unsigned CNT_MX = (FIRE_HOLD > FIRE_COOL) ? FIRE_HOLD : FIRE_COOL;
  localparam int unsigned CNT_W  = $clog2(CNT_MX + 1);

  localparam logic [X_W-1:0]   X_MIN_N   = X_W'(X_MIN);
  localparam logic [X_W-1:0]   X_MAX_N   = X_W'(X_MAX);
  localparam logic [X_W-1:0]   X_RESET_N = X_W'(X_RESET);
  localparam logic [XW1-1:0]   X_MIN_E   = XW1'(X_MIN);
  localparam logic [XW1-1:0]   X_MAX_E   = XW1'(X_MAX);
  localparam logic [XW1-1:0]   STEP_1    = XW1'(STEP);
  localparam logic [XW1-1:0]   STEP_2    = XW1'(2 * STEP);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(FIRE_HOLD - 1);
  localparam logic [CNT_W-1:0] COOL_LOAD = CNT_W'(FIRE_COOL - 1);

  if (!(X_MIN <= X_RESET && X_RESET <= X_MAX && X_MAX < (2 ** X_W))) begin : g_bad_x
    $error("player_ctrl: require X_MIN <= X_RESET <= X_MAX < 2**X_W");
  end
  if (!(STEP >= 1 && STEP <= X_MAX - X_MIN)) begin : g_bad_step
    $error("player_ctrl: require 1 <= STEP <= X_MAX-X_MIN");
  end
  if (MOVE_PERIOD < 2 || FIRE_HOLD < 1 || FIRE_COOL < 1) begin : g_bad_timing
    $error("player_ctrl: require MOVE_PERIOD >= 2, FIRE_HOLD >= 1, FIRE_COOL >= 1");
  end

  logic [3:0]       sync1_q, sync2_q;
  logic [3:0]       pressed_s;
  logic             right_s, left_s, fire_s, tick_s;
  logic [XW1-1:0]   step_s, x_ext_s, sum_s, diff_s;
  logic [X_W-1:0]   x_q, x_d, fire_x_q, fire_x_d;
  fire_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fire_start_q, fire_start_d;

  rate_tick #(.PERIOD(MOVE_PERIOD)) u_move_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .tick_o  (tick_s)
  );

  // Two-flop synchroniser; released buttons read as 1 out of reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q <= 4'hF;
      sync2_q <= 4'hF;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
    end
  end

  assign pressed_s = ~sync2_q;
  assign right_s   = pressed_s[0];
  assign left_s    = pressed_s[1];
  assign fire_s    = pressed_s[3];
  assign step_s    = pressed_s[2] ? STEP_2 : STEP_1;
  assign x_ext_s   = {1'b0, x_q};
  assign sum_s     = x_ext_s + step_s;
  assign diff_s    = x_ext_s - step_s;

  // Movement: one extra bit keeps sum/difference from wrapping before the clamp.
  always_comb begin
    x_d = x_q;
    if (tick_s && right_s && !left_s) begin
      x_d = (sum_s > X_MAX_E) ? X_MAX_N : X_W'(sum_s);
    end else if (tick_s && left_s && !right_s) begin
      x_d = (x_ext_s < X_MIN_E + step_s) ? X_MIN_N : X_W'(diff_s);
    end else begin
      x_d = x_q;
    end
  end

  // Fire FSM next state; one down-counter serves both ACTIVE and COOL.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    fire_x_d     = fire_x_q;
    fire_start_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fire_s) begin
          state_d      = ST_ACTIVE;
          cnt_d        = HOLD_LOAD;
          fire_x_d     = x_q;
          fire_start_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (cnt_q == '0) begin
          state_d = ST_COOL;
          cnt_d   = COOL_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_COOL: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Position and fire state registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      x_q          <= X_RESET_N;
      fire_x_q     <= X_RESET_N;
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      fire_start_q <= 1'b0;
    end else begin
      x_q          <= x_d;
      fire_x_q     <= fire_x_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      fire_start_q <= fire_start_d;
    end
  end

  assign x           = x_q;
  assign fire_x      = fire_x_q;
  assign fire_active = (state_q == ST_ACTIVE);
  assign fire_start  = fire_start_q;

  // Sprite datapath decode.
  always_comb begin
    op          = OP_DRAW;
    self_enable = 1'b0;
    case (self_state)
      SELF_DRAW: begin
        self_enable = 1'b1;
        op          = fire_active ? OP_SHOT : OP_DRAW;
      end
      SELF_ERASE: begin
        self_enable = 1'b1;
        op          = OP_ERASE;
      end
      default: begin
        self_enable = 1'b0;
        op          = OP_DRAW;
      end
    endcase
  end

endmodule : player_ctrl

// File: tb/tb_player_ctrl.sv
// Directed bench for player_ctrl with short move/fire timing; expected values
// are hand-derived from clock-edge counts after reset release.
module tb_player_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] key_n;
  logic [3:0] self_state;
  logic [1:0] op;
  logic       self_enable;
  logic [7:0] x;
  logic       fire_active;
  logic       fire_start;
  logic [7:0] fire_x;

  int checks   = 0;
  int failures = 0;

  player_ctrl #(
    .MOVE_PERIOD (4),
    .FIRE_HOLD   (5),
    .FIRE_COOL   (8)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .key_n       (key_n),
    .self_state  (self_state),
    .op          (op),
    .self_enable (self_enable),
    .x           (x),
    .fire_active (fire_active),
    .fire_start  (fire_start),
    .fire_x      (fire_x)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called on a negedge; release happens there so the next posedge is edge 1.
  task automatic reset_release(input logic [3:0] keys);
    reset_n = 1'b0;
    key_n   = 4'hF;
    cyc(2);
    key_n   = keys;
    reset_n = 1'b1;
  endtask

  function automatic int clamp_hi(input int v);
    return (v > 150) ? 150 : v;
  endfunction

  initial begin
    int exp_x;
    int fx_exp;
    logic fs_e, fa_e;

    reset_n    = 1'b0;
    key_n      = 4'hF;
    self_state = 4'd0;
    cyc(3);

    // Reset state
    check_eq("rst_x", x, 82);
    check_eq("rst_fire_x", fire_x, 82);
    check_eq("rst_fire_active", fire_active, 0);
    check_eq("rst_fire_start", fire_start, 0);
    check_eq("rst_en", self_enable, 0);
    check_eq("rst_op", op, 0);

    // 1: hold right, clamp at 150
    key_n   = 4'b1110;
    reset_n = 1'b1;
    cyc(3);
    check_eq("r_pre_tick", x, 82);
    cyc(1);
    check_eq("r_tick1", x, 92);
    exp_x = 92;
    for (int i = 0; i < 7; i++) begin
      cyc(2);
      check_eq("r_hold_between", x, exp_x);
      cyc(2);
      exp_x = clamp_hi(exp_x + 10);
      check_eq("r_tick", x, exp_x);
    end

    // 2: left + boost, clamp at 2
    reset_release(4'b1001);
    cyc(4);
    check_eq("lb_tick1", x, 62);
    exp_x = 62;
    for (int i = 0; i < 5; i++) begin
      cyc(4);
      exp_x = (exp_x - 20 < 2) ? 2 : exp_x - 20;
      check_eq("lb_tick", x, exp_x);
    end

    // 3: both directions pressed, op decode
    reset_release(4'b1100);
    self_state = 4'd2;
    for (int i = 0; i < 10; i++) begin
      cyc(4);
      check_eq("both_x", x, 82);
    end
    check_eq("erase_op", op, 1);
    check_eq("erase_en", self_enable, 1);
    self_state = 4'd0;
    cyc(1);
    check_eq("idle_en", self_enable, 0);
    check_eq("idle_op", op, 0);
    self_state = 4'd1;
    cyc(1);
    check_eq("draw_en", self_enable, 1);
    check_eq("draw_op", op, 0);

    // 4: single fire press, cooldown press ignored
    reset_release(4'b0111);
    cyc(1);
    key_n = 4'hF;
    check_eq("f1_e1_start", fire_start, 0);
    cyc(1);
    check_eq("f1_e2_start", fire_start, 0);
    check_eq("f1_e2_active", fire_active, 0);
    cyc(1);
    check_eq("f1_e3_start", fire_start, 1);
    check_eq("f1_e3_active", fire_active, 1);
    check_eq("f1_e3_fire_x", fire_x, 82);
    check_eq("f1_e3_op", op, 2);
    cyc(1);
    check_eq("f1_e4_start", fire_start, 0);
    check_eq("f1_e4_active", fire_active, 1);
    for (int i = 5; i <= 7; i++) begin
      cyc(1);
      check_eq("f1_hold_active", fire_active, 1);
    end
    cyc(1);
    check_eq("f1_e8_active", fire_active, 0);
    check_eq("f1_e8_op", op, 0);
    cyc(1);
    key_n = 4'b0111;
    cyc(1);
    key_n = 4'hF;
    for (int i = 11; i <= 24; i++) begin
      cyc(1);
      check_eq("cool_press_active", fire_active, 0);
      check_eq("cool_press_start", fire_start, 0);
    end

    // 5: held fire + right, auto-fire period 14, fire_x latched per shot
    self_state = 4'd1;
    reset_release(4'b0110);
    fx_exp = 82;
    for (int i = 1; i <= 60; i++) begin
      cyc(1);
      fs_e = (i >= 3) && (((i - 3) % 14) == 0);
      fa_e = (i >= 3) && (((i - 3) % 14) < 5);
      if (fs_e) fx_exp = clamp_hi(82 + 10 * ((i - 1) / 4));
      check_eq("auto_start", fire_start, fs_e);
      check_eq("auto_active", fire_active, fa_e);
      check_eq("auto_op", op, fa_e ? 2 : 0);
      check_eq("auto_x", x, clamp_hi(82 + 10 * (i / 4)));
      check_eq("auto_fire_x", fire_x, fx_exp);
    end
    key_n = 4'hF;

    // 6: reset during ACTIVE, then fire resumes
    self_state = 4'd0;
    reset_release(4'b1110);
    cyc(8);
    check_eq("mid_pre_x", x, 102);
    key_n = 4'b0110;
    cyc(3);
    check_eq("mid_start", fire_start, 1);
    check_eq("mid_fire_x", fire_x, 102);
    cyc(1);
    check_eq("mid_active", fire_active, 1);
    check_eq("mid_x", x, 112);
    reset_n = 1'b0;
    cyc(1);
    check_eq("abort_active", fire_active, 0);
    check_eq("abort_start", fire_start, 0);
    check_eq("abort_x", x, 82);
    check_eq("abort_fire_x", fire_x, 82);
    reset_n = 1'b1;
    cyc(3);
    check_eq("resume_start", fire_start, 1);
    check_eq("resume_active", fire_active, 1);
    check_eq("resume_fire_x", fire_x, 82);
    cyc(1);
    check_eq("resume_start_drop", fire_start, 0);
    check_eq("resume_active_hold", fire_active, 1);
    key_n = 4'hF;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_player_ctrl
